led_display_shift_receiver: RTL and testbench
=============================================

// Module: led_display_shift_receiver
// PURPOSE
//  Receiving end of the two-channel shift-register LED display link (ds/cp/mr_n per channel).
//  Deserialises channel A (segment byte) and channel B (digit-select byte).
//  Decodes each completed frame back to a hex nibble and rebuilds the 16-bit displayed number.
//  Used for loopback checking of the display controller on the board and in simulation.
// PARAMETERS
//  SYNC_STAGES     2  input synchroniser depth per pin, >=2
//  SEG_ACTIVE_LOW  0  1: invert channel A byte before decode
//  SEL_ACTIVE_LOW  0  1: invert channel B byte before decode
// PORTS
//  i_clk             in   1   system clock
//  i_reset           in   1   async active-high reset
//  i_shifter_a_ds    in   1   channel A serial data (segments)
//  i_shifter_a_cp    in   1   channel A shift clock, rising edge shifts
//  i_shifter_a_mr_n  in   1   channel A clear, active low
//  i_shifter_b_ds    in   1   channel B serial data (digit select)
//  i_shifter_b_cp    in   1   channel B shift clock
//  i_shifter_b_mr_n  in   1   channel B clear, active low
//  o_number          out  16  reconstructed number, digit k = o_number[4k+3:4k]
//  o_digit_valid     out  4   sticky: digit k written at least once since reset
//  o_frame_stb       out  1   1-cycle pulse: valid frame decoded and written
//  o_number_stb      out  1   1-cycle pulse: all 4 digits rewritten since previous pulse
// BEHAVIOUR
//  - Reset: o_number=0, o_digit_valid=0, strobes 0, shift regs/counters 0; sync cp/ds stages 0.
//  - Reset: sync mr_n stages 0, so each channel stays cleared until mr_n is seen high.
//  - Each of the 6 pins passes through SYNC_STAGES flops; cp rise = cp_sync & ~cp_sync_d.
//  - Input timing: cp high and low each >= SYNC_STAGES+1 cycles; ds stable across that window.
//  - Per channel: mr_n_sync low -> sr=0, cnt=0, done=0. Clear wins over a same-cycle cp rise.
//  - Channel shift: on cp rise with cnt<8, sr<={sr[6:0],ds} (MSB first) and cnt++.
//  - Channel done: cnt==8 sets done. Rises while done leave sr unchanged and set overshift.
//  - Frame: both done and !used -> decode registered next cycle, then used=1.
//  - used clears only when both channels have been cleared by mr_n (mr_n low seen on each).
//  - Latency: o_frame_stb fires SYNC_STAGES+2 i_clk edges after the first edge sampling
//    the 8th cp rise of the later-completing channel.
//  - Select: B (after SEL_ACTIVE_LOW) must be exactly 0x01/0x02/0x04/0x08 -> idx 0..3.
//  - Segments: A[6:0]=gfedcba (after SEG_ACTIVE_LOW); A[7] (dp) ignored. Patterns:
//    0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  - Valid frame (legal select, table match, no overshift): o_number[4idx+:4]<=nibble,
//    o_digit_valid[idx]<=1, o_frame_stb=1, written_mask[idx]<=1.
//  - Invalid frame: no state change except used=1.
//  - written_mask==4'hF after an update -> o_number_stb=1 the same cycle o_number settles;
//    written_mask<=0.
//  - Same digit written again before the mask fills is legal; the latest value wins.
//  - Channels are independent: either may complete first; A and B cp edges may coincide.
//  - i_reset mid-frame aborts everything immediately (async); no strobe is emitted.
// CONFIGURATION
//  LED_SHIFT_RX_ERR_EN defined: adds ports o_frame_err_stb (1) and o_err_count (8).
//  - o_frame_err_stb pulses on an invalid frame, in the slot o_frame_stb would use.
//  - o_err_count increments on each invalid frame and saturates at 8'hFF; both reset to 0.
//  LED_SHIFT_RX_ERR_EN undefined: ports absent; invalid frames are silently dropped.
// TESTING
//  - Reset release, idle pins -> all outputs 0, no strobes for 1000 cycles.
//  - Frames idx0..3 with A=3F,06,5B,4F and B=01,02,04,08 ->
//    4 o_frame_stb, one o_number_stb, o_number=16'h3210, o_digit_valid=4'hF.
//  - A=77 on idx2 with B's 8 bits sent before A's ->
//    o_number[11:8]=4'hA; o_frame_stb SYNC_STAGES+2 edges after A's 8th rise.
//  - B=03 or A=00 or a 9th cp rise on A -> no o_frame_stb, o_number unchanged;
//    with LED_SHIFT_RX_ERR_EN: o_frame_err_stb once, o_err_count+1.
//  - mr_n_a low on the same cycle as a cp_a rise, or i_reset after 5 bits ->
//    channel cleared, next full frame decodes correctly.
//  - 300 invalid frames with LED_SHIFT_RX_ERR_EN -> o_err_count stays 8'hFF.

Source files
------------

// File: rtl/led_display_shift_receiver.sv
// rtl/led_display_shift_receiver.sv - two-channel LED shift-link receiver, decodes frames back to a 16-bit number
// Optional LED_SHIFT_RX_ERR_EN adds o_frame_err_stb / o_err_count for invalid frames.
module led_display_shift_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_shifter_a_ds,
  input  logic        i_shifter_a_cp,
  input  logic        i_shifter_a_mr_n,
  input  logic        i_shifter_b_ds,
  input  logic        i_shifter_b_cp,
  input  logic        i_shifter_b_mr_n,
  output logic [15:0] o_number,
  output logic [3:0]  o_digit_valid,
  output logic        o_frame_stb,
  output logic        o_number_stb
`ifdef LED_SHIFT_RX_ERR_EN
  ,
  output logic        o_frame_err_stb,
  output logic [7:0]  o_err_count
`endif
);

  // Pin bit 3c = ds, 3c+1 = cp, 3c+2 = mr_n for channel c (0 = A, 1 = B).
  logic [5:0] pins;
  assign pins = {i_shifter_b_mr_n, i_shifter_b_cp, i_shifter_b_ds,
                 i_shifter_a_mr_n, i_shifter_a_cp, i_shifter_a_ds};

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [5:0] pin_s;
  logic [1:0] cp_dly_q, cp_dly_d, cp_rise, mr_s, ds_s;
  logic [7:0] sr_q [2];
  logic [7:0] sr_d [2];
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] done_q, done_d, ovs_q, ovs_d, clr_seen_q, clr_seen_d;
  logic       used_q, used_d;
  logic [15:0] number_q, number_d;
  logic [3:0]  digit_valid_q, digit_valid_d, mask_q, mask_d, mask_new;
  logic        frame_stb_q, frame_stb_d, number_stb_q, number_stb_d;
  logic        fire, sel_ok, seg_ok, frame_ok;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic [7:0]  seg, sel;

  assign pin_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = pins;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    for (int c = 0; c < 2; c++) begin
      ds_s[c]     = pin_s[3*c];
      cp_dly_d[c] = pin_s[3*c+1];
      mr_s[c]     = pin_s[3*c+2];
      cp_rise[c]  = pin_s[3*c+1] & ~cp_dly_q[c];
    end
  end

  // Clear has priority over a coincident shift edge.
  always_comb begin
    done_d = done_q;
    ovs_d  = ovs_q;
    for (int c = 0; c < 2; c++) begin
      sr_d[c]  = sr_q[c];
      cnt_d[c] = cnt_q[c];
      if (!mr_s[c]) begin
        sr_d[c]   = '0;
        cnt_d[c]  = '0;
        done_d[c] = 1'b0;
        ovs_d[c]  = 1'b0;
      end else begin
        if (cnt_q[c] == 4'd8) done_d[c] = 1'b1;
        if (cp_rise[c]) begin
          if (!cnt_q[c][3]) begin
            sr_d[c]  = {sr_q[c][6:0], ds_s[c]};
            cnt_d[c] = cnt_q[c] + 4'd1;
          end else begin
            ovs_d[c] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    seg    = sr_q[0] ^ {8{SEG_ACTIVE_LOW}};
    sel    = sr_q[1] ^ {8{SEL_ACTIVE_LOW}};
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (sel)
      8'h01:   idx = 2'd0;
      8'h02:   idx = 2'd1;
      8'h04:   idx = 2'd2;
      8'h08:   idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
    seg_ok = 1'b1;
    nib    = 4'h0;
    case (seg[6:0])
      7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
    frame_ok = sel_ok & seg_ok & ~ovs_q[0] & ~ovs_q[1];
    fire     = done_q[0] & done_q[1] & ~used_q;
  end

  // A frame is consumed once; re-arming needs a clear seen on both channels afterwards.
  always_comb begin
    clr_seen_d = fire ? 2'b00 : (clr_seen_q | ~mr_s);
    used_d     = used_q;
    if (fire) used_d = 1'b1;
    else if (used_q && (&clr_seen_q)) used_d = 1'b0;
  end

  always_comb begin
    number_d      = number_q;
    digit_valid_d = digit_valid_q;
    mask_d        = mask_q;
    frame_stb_d   = 1'b0;
    number_stb_d  = 1'b0;
    mask_new      = mask_q | (4'b0001 << idx);
    if (fire && frame_ok) begin
      number_d[{idx, 2'b00} +: 4] = nib;
      digit_valid_d[idx]          = 1'b1;
      frame_stb_d                 = 1'b1;
      if (mask_new == 4'hF) begin
        number_stb_d = 1'b1;
        mask_d       = 4'h0;
      end else begin
        mask_d = mask_new;
      end
    end
  end

`ifdef LED_SHIFT_RX_ERR_EN
  logic       err_stb_q, err_stb_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_stb_d = fire & ~frame_ok;
    err_cnt_d = (err_stb_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_stb_q <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      err_stb_q <= err_stb_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_frame_err_stb = err_stb_q;
  assign o_err_count     = err_cnt_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q   <= '0;
      cp_dly_q <= '0;
      for (int c = 0; c < 2; c++) begin
        sr_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      done_q        <= '0;
      ovs_q         <= '0;
      clr_seen_q    <= '0;
      used_q        <= 1'b0;
      number_q      <= '0;
      digit_valid_q <= '0;
      mask_q        <= '0;
      frame_stb_q   <= 1'b0;
      number_stb_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cp_dly_q <= cp_dly_d;
      for (int c = 0; c < 2; c++) begin
        sr_q[c]  <= sr_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      done_q        <= done_d;
      ovs_q         <= ovs_d;
      clr_seen_q    <= clr_seen_d;
      used_q        <= used_d;
      number_q      <= number_d;
      digit_valid_q <= digit_valid_d;
      mask_q        <= mask_d;
      frame_stb_q   <= frame_stb_d;
      number_stb_q  <= number_stb_d;
    end
  end

  assign o_number      = number_q;
  assign o_digit_valid = digit_valid_q;
  assign o_frame_stb   = frame_stb_q;
  assign o_number_stb  = number_stb_q;

endmodule

// File: tb/tb_led_display_shift_receiver.sv
// tb/tb_led_display_shift_receiver.sv - directed and randomized frames against a table-driven reference model
module tb_led_display_shift_receiver;
  localparam int S    = 2;
  localparam int HOLD = S + 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst;
  logic a_ds, a_cp, a_mr_n, b_ds, b_cp, b_mr_n;
  logic [15:0] o_number;
  logic [3:0]  o_digit_valid;
  logic        o_frame_stb, o_number_stb;
`ifdef LED_SHIFT_RX_ERR_EN
  logic        o_frame_err_stb;
  logic [7:0]  o_err_count;
`endif

  led_display_shift_receiver dut (
    .i_clk(clk), .i_reset(rst),
    .i_shifter_a_ds(a_ds), .i_shifter_a_cp(a_cp), .i_shifter_a_mr_n(a_mr_n),
    .i_shifter_b_ds(b_ds), .i_shifter_b_cp(b_cp), .i_shifter_b_mr_n(b_mr_n),
    .o_number(o_number), .o_digit_valid(o_digit_valid),
    .o_frame_stb(o_frame_stb), .o_number_stb(o_number_stb)
`ifdef LED_SHIFT_RX_ERR_EN
    , .o_frame_err_stb(o_frame_err_stb), .o_err_count(o_err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_frame = 0, n_num = 0, n_err = 0, last_frame_cyc = 0, last_rise_edge = 0;
  always @(negedge clk) begin
    if (o_frame_stb) begin
      n_frame++;
      last_frame_cyc = cyc;
    end
    if (o_number_stb) n_num++;
`ifdef LED_SHIFT_RX_ERR_EN
    if (o_frame_err_stb) n_err++;
`endif
  end

  int vectors = 0, miscompares = 0;
  int f0, n0, e0;
  logic [15:0] m_num = '0;
  logic [3:0]  m_dv = '0, m_mask = '0;
  int          m_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seg_nib(input logic [6:0] s);
    for (int n = 0; n < 16; n++) if (SEG_TAB[n] == s) return n;
    return -1;
  endfunction

  task automatic snap();
    f0 = n_frame; n0 = n_num; e0 = n_err;
  endtask

  task automatic pulse(input bit do_a, input bit do_b, input bit da, input bit db);
    @(negedge clk);
    if (do_a) a_ds = da;
    if (do_b) b_ds = db;
    @(negedge clk);
    if (do_a) a_cp = 1'b1;
    if (do_b) b_cp = 1'b1;
    last_rise_edge = cyc + 1;
    repeat (HOLD) @(negedge clk);
    a_cp = 1'b0; b_cp = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic clear_both();
    @(negedge clk);
    a_mr_n = 1'b0; b_mr_n = 1'b0;
    repeat (HOLD) @(negedge clk);
    a_mr_n = 1'b1; b_mr_n = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int order, input bit extra);
    if (order == 2) begin
      for (int i = 7; i >= 0; i--) pulse(1, 1, a[i], b[i]);
    end else if (order == 1) begin
      for (int i = 7; i >= 0; i--) pulse(0, 1, 0, b[i]);
      for (int i = 7; i >= 0; i--) pulse(1, 0, a[i], 0);
    end else begin
      for (int i = 7; i >= 0; i--) pulse(1, 0, a[i], 0);
      if (extra) pulse(1, 0, 1, 0);
      for (int i = 7; i >= 0; i--) pulse(0, 1, 0, b[i]);
    end
  endtask

  task automatic check_frame(input logic [7:0] a, input logic [7:0] b, input bit extra);
    int nib, idx;
    bit ok, nstb;
    nib = seg_nib(a[6:0]);
    idx = -1;
    nstb = 1'b0;
    for (int k = 0; k < 4; k++) if (b == 8'(1 << k)) idx = k;
    ok = (nib >= 0) && (idx >= 0) && !extra;
    if (ok) begin
      m_num[idx*4 +: 4] = nib[3:0];
      m_dv[idx] = 1'b1;
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        nstb = 1'b1;
        m_mask = 4'h0;
      end
    end else if (m_err < 255) begin
      m_err++;
    end
    repeat (4) @(negedge clk);
    check("frame_stb_count", n_frame - f0, ok);
    check("number_stb_count", n_num - n0, nstb);
    check("number", o_number, m_num);
    check("digit_valid", o_digit_valid, m_dv);
`ifdef LED_SHIFT_RX_ERR_EN
    check("err_stb_count", n_err - e0, !ok);
    check("err_count", o_err_count, m_err);
`endif
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input int order, input bit extra);
    snap();
    clear_both();
    send_frame(a, b, order, extra);
    check_frame(a, b, extra);
  endtask

  initial begin
    int nt;
    logic [7:0] ra, rb;
    int ord, kind, nib, idx;
    bit ext;

    rst = 1'b1;
    a_ds = 0; a_cp = 0; a_mr_n = 1; b_ds = 0; b_cp = 0; b_mr_n = 1;
    repeat (3) @(negedge clk);
    check("reset_number", o_number, 16'h0);
    check("reset_digit_valid", o_digit_valid, 4'h0);
    check("reset_strobes", {o_frame_stb, o_number_stb}, 2'b00);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_frame_stb", n_frame, 0);
    check("idle_number_stb", n_num, 0);
    check("idle_number", o_number, 16'h0);
`ifdef LED_SHIFT_RX_ERR_EN
    check("idle_err_count", o_err_count, 8'h00);
`endif

    nt = n_num;
    do_frame(8'h3F, 8'h01, 0, 0);
    do_frame(8'h06, 8'h02, 1, 0);
    do_frame(8'h5B, 8'h04, 2, 0);
    do_frame(8'h4F, 8'h08, 0, 0);
    check("four_digits_number_stb", n_num - nt, 1);
    check("four_digits_number", o_number, 16'h3210);
    check("four_digits_valid", o_digit_valid, 4'hF);

    do_frame(8'h77, 8'h04, 1, 0);
    check("b_first_latency", last_frame_cyc - last_rise_edge, S + 2);
    check("b_first_nibble", o_number[11:8], 4'hA);

    do_frame(8'h06, 8'h03, 0, 0);
    do_frame(8'h00, 8'h01, 1, 0);
    do_frame(8'h5B, 8'h02, 0, 1);

    clear_both();
    for (int i = 0; i < 3; i++) pulse(1, 0, 1, 0);
    @(negedge clk);
    a_mr_n = 1'b0; a_cp = 1'b1; a_ds = 1'b1;
    repeat (HOLD) @(negedge clk);
    a_mr_n = 1'b1; a_cp = 1'b0;
    repeat (HOLD) @(negedge clk);
    snap();
    send_frame(8'h7D, 8'h08, 2, 0);
    check_frame(8'h7D, 8'h08, 0);

    clear_both();
    snap();
    for (int i = 0; i < 5; i++) pulse(1, 0, i[0], 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_abort_number", o_number, 16'h0);
    check("reset_abort_digit_valid", o_digit_valid, 4'h0);
    rst = 1'b0;
    m_num = '0; m_dv = '0; m_mask = '0; m_err = 0;
    repeat (HOLD) @(negedge clk);
    check("reset_abort_no_stb", n_frame - f0, 0);
    snap();
    send_frame(8'h39, 8'h01, 0, 0);
    check_frame(8'h39, 8'h01, 0);

    for (int i = 0; i < 40; i++) begin
      nib  = $urandom_range(0, 15);
      idx  = $urandom_range(0, 3);
      ra   = {1'($urandom_range(0, 1)), SEG_TAB[nib]};
      rb   = 8'(1 << idx);
      kind = $urandom_range(0, 7);
      ord  = $urandom_range(0, 2);
      ext  = 1'b0;
      if (kind == 0) rb = 8'($urandom);
      if (kind == 1) ra = 8'($urandom);
      if (kind == 2) begin
        ext = 1'b1;
        ord = 0;
      end
      do_frame(ra, rb, ord, ext);
    end

`ifdef LED_SHIFT_RX_ERR_EN
    for (int i = 0; i < 300; i++) do_frame(8'h06, 8'h03, 2, 0);
    check("err_count_saturated", o_err_count, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
